// File: rtl/eq_serial_ctrl_if.sv
// Handshake and result bundle for the bit-serial equality controller.
// The master drives the request; the slave returns status and result.
interface eq_serial_ctrl_if #(
  parameter int W  = 8,
  parameter int IW = 3
);
  logic          start;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          ready;
  logic          done_tick;
  logic          eq;
  logic [IW-1:0] mis_idx;

  modport master (
    output start, a, b,
    input  ready, done_tick, eq, mis_idx
  );

  modport slave (
    input  start, a, b,
    output ready, done_tick, eq, mis_idx
  );
endinterface

// File: rtl/eq_serial_ctrl.sv
// Bit-serial word-equality controller: one shared 1-bit equality cell walks
// the captured operands LSB-first, one bit per clock.
module eq_serial_ctrl #(
  parameter int W     = 8,
  parameter int IW    = 3,
  parameter int EARLY = 1
) (
  input  logic             clk,
  input  logic             reset,
  eq_serial_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OP   = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, b_q;
  logic [IW-1:0] n_q;
  logic          acc_q;
  logic          seen_q;
  logic [IW-1:0] idx_q;
  logic          eq_q;
  logic [IW-1:0] mis_idx_q;

  logic          bit_eq;
  logic          acc_final;
  logic [IW-1:0] idx_final;
  logic          last_bit;
  logic          finish;
  logic          ready_d;
  logic          done_d;

  // The single shared comparator cell.
  assign bit_eq    = (~a_q[0] & ~b_q[0]) | (a_q[0] & b_q[0]);
  assign acc_final = acc_q & bit_eq;
  // A mismatch in the current cycle is the lowest one only if none was seen yet.
  assign idx_final = seen_q ? idx_q : n_q;
  assign last_bit  = (n_q == IW'(W - 1));
  assign finish    = last_bit || ((EARLY != 0) && !bit_eq);

  always_comb begin
    state_d = state_q;
    ready_d = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (bus.start) state_d = S_OP;
      end
      S_OP: begin
        if (finish) state_d = S_DONE;
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      n_q       <= '0;
      acc_q     <= 1'b0;
      seen_q    <= 1'b0;
      idx_q     <= '0;
      eq_q      <= 1'b0;
      mis_idx_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            a_q    <= bus.a;
            b_q    <= bus.b;
            n_q    <= '0;
            acc_q  <= 1'b1;
            seen_q <= 1'b0;
          end
        end
        S_OP: begin
          acc_q <= acc_final;
          a_q   <= {1'b0, a_q[W-1:1]};
          b_q   <= {1'b0, b_q[W-1:1]};
          if (!last_bit) n_q <= n_q + 1'b1;
          if (!bit_eq && !seen_q) begin
            idx_q  <= n_q;
            seen_q <= 1'b1;
          end
          // Result registers are loaded on the transition into done.
          if (finish) begin
            eq_q      <= acc_final;
            mis_idx_q <= acc_final ? '0 : idx_final;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready     = ready_d;
  assign bus.done_tick = done_d;
  assign bus.eq        = eq_q;
  assign bus.mis_idx   = mis_idx_q;

endmodule

// File: tb/tb_eq_serial_ctrl.sv
// Bench for eq_serial_ctrl: an EARLY=1 and an EARLY=0 instance run the same
// stimulus back-to-back; expectations come from a word-level model.
module tb_eq_serial_ctrl;
  localparam int W  = 8;
  localparam int IW = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  eq_serial_ctrl_if #(.W(W), .IW(IW)) if_e ();
  eq_serial_ctrl_if #(.W(W), .IW(IW)) if_f ();

  eq_serial_ctrl #(.W(W), .IW(IW), .EARLY(1)) dut_e (.clk(clk), .reset(reset), .bus(if_e.slave));
  eq_serial_ctrl #(.W(W), .IW(IW), .EARLY(0)) dut_f (.clk(clk), .reset(reset), .bus(if_f.slave));

  int checks = 0;
  int errors = 0;

  logic          prev_eq  [2];
  logic [IW-1:0] prev_idx [2];

  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          exp_eq;
    logic [IW-1:0] exp_idx;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_dut(input string tag, input int k, input logic e_rdy, input logic e_done,
                         input logic e_eq, input logic [IW-1:0] e_idx);
    logic r, d, q;
    logic [IW-1:0] i;
    if (k == 0) begin
      r = if_e.ready; d = if_e.done_tick; q = if_e.eq; i = if_e.mis_idx;
    end else begin
      r = if_f.ready; d = if_f.done_tick; q = if_f.eq; i = if_f.mis_idx;
    end
    chk($sformatf("%s_d%0d_ready", tag, k), {31'b0, r}, {31'b0, e_rdy});
    chk($sformatf("%s_d%0d_done", tag, k), {31'b0, d}, {31'b0, e_done});
    chk($sformatf("%s_d%0d_eq", tag, k), {31'b0, q}, {31'b0, e_eq});
    chk($sformatf("%s_d%0d_idx", tag, k), 32'(i), 32'(e_idx));
  endtask

  task automatic drive(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    if_e.start = s; if_e.a = a; if_e.b = b;
    if_f.start = s; if_f.a = a; if_f.b = b;
  endtask

  // Entered and left at posedge+1; leaving is cycle 0 of the next run.
  task automatic idle(input int n, input string tag);
    for (int c = 0; c < n; c++) begin
      drive(1'b0, W'($urandom), W'($urandom));
      @(negedge clk);
      for (int k = 0; k < 2; k++) chk_dut(tag, k, 1'b1, 1'b0, prev_eq[k], prev_idx[k]);
      @(posedge clk); #1;
    end
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input bit use_t,
                     input logic t_eq, input logic [IW-1:0] t_idx, input string tag);
    logic [W-1:0]  diff;
    logic          n_eq;
    logic [IW-1:0] n_idx;
    int            lat [2];
    diff  = a ^ b;
    n_eq  = (diff == '0);
    n_idx = '0;
    for (int i = W - 1; i >= 0; i--) if (diff[i]) n_idx = IW'(i);
    if (use_t) begin
      n_eq  = t_eq;
      n_idx = t_idx;
    end
    lat[0] = n_eq ? W + 1 : int'(n_idx) + 2;
    lat[1] = W + 1;

    drive(1'b1, a, b);
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk_dut({tag, "_c0"}, k, 1'b1, 1'b0, prev_eq[k], prev_idx[k]);

    for (int c = 1; c <= W + 1; c++) begin
      @(posedge clk); #1;
      // Starts while busy carry garbage operands and must be ignored.
      if (c < lat[0] && ($urandom_range(0, 1) == 1)) drive(1'b1, W'($urandom), W'($urandom));
      else drive(1'b0, W'($urandom), W'($urandom));
      @(negedge clk);
      for (int k = 0; k < 2; k++)
        chk_dut($sformatf("%s_c%0d", tag, c), k, c > lat[k], c == lat[k],
                (c >= lat[k]) ? n_eq : prev_eq[k],
                (c >= lat[k]) ? n_idx : prev_idx[k]);
    end
    for (int k = 0; k < 2; k++) begin
      prev_eq[k]  = n_eq;
      prev_idx[k] = n_eq ? '0 : n_idx;
    end
    $display("%s a=%02h b=%02h eq=%0d idx=%0d lat_early=%0d lat_full=%0d",
             tag, a, b, n_eq, n_idx, lat[0], lat[1]);
    @(posedge clk); #1;
  endtask

  initial begin
    tbl[0] = '{a: 8'hA5, b: 8'hA5, exp_eq: 1'b1, exp_idx: 3'd0};
    tbl[1] = '{a: 8'h0F, b: 8'h0B, exp_eq: 1'b0, exp_idx: 3'd2};
    tbl[2] = '{a: 8'h0F, b: 8'h03, exp_eq: 1'b0, exp_idx: 3'd2};
    tbl[3] = '{a: 8'hFF, b: 8'hFF, exp_eq: 1'b1, exp_idx: 3'd0};
    tbl[4] = '{a: 8'h80, b: 8'h00, exp_eq: 1'b0, exp_idx: 3'd7};
    tbl[5] = '{a: 8'h01, b: 8'h00, exp_eq: 1'b0, exp_idx: 3'd0};
    tbl[6] = '{a: 8'h00, b: 8'hFF, exp_eq: 1'b0, exp_idx: 3'd0};

    for (int k = 0; k < 2; k++) begin
      prev_eq[k]  = 1'b0;
      prev_idx[k] = '0;
    end

    drive(1'b0, '0, '0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    idle(6, "reset_idle");

    for (int t = 0; t < 7; t++)
      run(tbl[t].a, tbl[t].b, 1'b1, tbl[t].exp_eq, tbl[t].exp_idx, $sformatf("tbl%0d", t));

    for (int r = 0; r < 40; r++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      case ($urandom_range(0, 2))
        0:       rb = ra;
        1:       rb = ra ^ (W'(1) << $urandom_range(0, W - 1));
        default: rb = W'($urandom);
      endcase
      run(ra, rb, 1'b0, 1'b0, '0, $sformatf("rnd%0d", r));
    end

    // Leave eq=1 behind so the reset below visibly clears it.
    run(8'h5A, 8'h5A, 1'b0, 1'b0, '0, "pre_rst");

    // Abandon a comparison with reset in cycle 3, start asserted alongside it.
    drive(1'b1, 8'h3C, 8'h3C);
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      if (c == 3) begin
        reset = 1'b1;
        drive(1'b1, 8'h12, 8'h34);
      end else begin
        drive(1'b0, W'($urandom), W'($urandom));
      end
      @(negedge clk);
      for (int k = 0; k < 2; k++) chk_dut($sformatf("rst_c%0d", c), k, 1'b0, 1'b0, prev_eq[k], prev_idx[k]);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      prev_eq[k]  = 1'b0;
      prev_idx[k] = '0;
    end
    $display("mid_op_reset a=3c b=3c abandoned in cycle 3");
    idle(9, "post_rst");

    run(8'h3C, 8'h3C, 1'b0, 1'b0, '0, "after_rst");
    run(8'h3C, 8'h34, 1'b0, 1'b0, '0, "after_rst2");
    idle(2, "tail");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
